fp_align_pipe: RTL
==================

// Module: fp_align_pipe
// PURPOSE
//  Two-stage pipelined, parametrised IEEE-style operand alignment for the FP adder datapath.
//  Unpacks two packed operands, picks the larger exponent, right-shifts the smaller mantissa.
//  Adds a valid/ready handshake, denormal hidden-bit handling and shift saturation.
//  Sits between operand capture and the mantissa add/normalise stages.
// PARAMETERS
//  EXP_W  8   exponent field width
//  MAN_W  23  stored mantissa field width; packed operand width W = 1+EXP_W+MAN_W
// PORTS
//  clk               in   1        clock; all state updates on rising edge
//  reset             in   1        synchronous, active-high reset
//  in_valid          in   1        operand pair valid
//  in_ready          out  1        block accepts pair this cycle
//  a, b              in   W        packed operands {sign, exponent, mantissa}
//  out_valid         out  1        aligned result valid
//  out_ready         in   1        downstream accepts result
//  sign_a, sign_b    out  1        operand signs, passed through
//  exponent_out      out  EXP_W    max(expA, expB), raw field value
//  a_larger          out  1        1 when expA >= expB (A not shifted)
//  aligned_a/_b      out  MW       aligned extended mantissas; MW = MAN_W+1 (+3 with GRS)
// BEHAVIOUR
//  - Reset (sync, high): both stage valids cleared; out_valid=0; all data outputs 0.
//  - Latency 2 cycles from accepted input to out_valid, throughput 1/cycle with no stalls.
//  - Stage 1 registers: signs, raw exps, extended mantissas, |expA-expB|, a_larger.
//  - Stage 2 registers: shift result; output ports driven directly from stage-2 regs.
//  - Hidden bit = 1 when exponent field != 0, else 0; exponent 0 treated as 1 for diff.
//  - Tie (expA == expB): a_larger=1, exponent_out=expA, no shift on either mantissa.
//  - Shift distance d saturates: d >= MW -> shifted mantissa = 0 (sticky per option).
//  - Handshake: s2_load = !s2_valid | out_ready; s1_load = !s1_valid | s2_load;
//    in_ready = s1_load (combinational from out_ready allowed); transfer on valid&ready.
//  - Held output: while out_valid & !out_ready, all outputs stable; no data lost or duplicated.
//  - in_valid low with s1_load: bubble propagates (valid=0), data regs may hold.
//  - Simultaneous accept and drain on full pipe: both stages advance same cycle.
//  - Reset mid-operation: in-flight pairs discarded; first post-reset pair out 2 cycles later.
//  - NaN/Inf not special-cased: exponent all-ones treated as ordinary field.
// CONFIGURATION
//  FPALIGN_GRS_EN defined: MW = MAN_W+4; mantissa = {hidden, man, g, r, s} with g=r=s=0
//    pre-shift; bits shifted past r OR into sticky s; saturated shift gives s = |mantissa.
//  FPALIGN_GRS_EN undefined: MW = MAN_W+1; bits shifted out are discarded (truncation).
// TESTING
//  a=3F800000,b=40000000 (1.0,2.0) -> exp_out=80, a_larger=0, aligned_a=400000, aligned_b=800000.
//  a=b=3FC00000 -> exp_out=7F, a_larger=1, aligned_a=aligned_b=C00000, no shift.
//  a=4B000000,b=00000001 (denormal) -> aligned_b=0; with GRS_EN sticky=1, aligned_b=0000001.
//  out_ready=0 for 5 cycles, 4 pairs offered -> in_ready drops after 2 accepted; order kept.
//  back-to-back 100 random pairs, out_ready=1 -> one result/cycle, each matches ref model.
//  reset asserted with 2 pairs in flight -> out_valid=0 next cycle, outputs 0, none emitted.

Source files
------------

// File: rtl/fp_align_if.sv
// Operand/result handshake bundle for fp_align_pipe.
// MW follows FPALIGN_GRS_EN exactly as in the datapath.
interface fp_align_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;
`ifdef FPALIGN_GRS_EN
    localparam int MW = MAN_W + 4;
`else
    localparam int MW = MAN_W + 1;
`endif

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic             sign_a;
    logic             sign_b;
    logic [EXP_W-1:0] exponent_out;
    logic             a_larger;
    logic [MW-1:0]    aligned_a;
    logic [MW-1:0]    aligned_b;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sign_a, sign_b,
        input  exponent_out, a_larger, aligned_a, aligned_b
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sign_a, sign_b,
        output exponent_out, a_larger, aligned_a, aligned_b
    );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage FP operand alignment: unpack, pick max exponent, shift smaller mantissa.
// FPALIGN_GRS_EN adds guard/round/sticky bits below the mantissa.
module fp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        reset,
    fp_align_if.slave   bus
);
    localparam int W = 1 + EXP_W + MAN_W;
`ifdef FPALIGN_GRS_EN
    localparam int MW = MAN_W + 4;
`else
    localparam int MW = MAN_W + 1;
`endif

    function automatic logic [MW-1:0] ext(
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] m
    );
`ifdef FPALIGN_GRS_EN
        return {|e, m, 3'b000};
`else
        return {|e, m};
`endif
    endfunction

    // Distances of MW or more clear the mantissa; sticky keeps any lost one.
    function automatic logic [MW-1:0] align(
        input logic [MW-1:0]    m,
        input logic [EXP_W-1:0] d
    );
        logic [MW-1:0] r;
`ifdef FPALIGN_GRS_EN
        logic lost;
`endif
        if (int'(d) >= MW)
            r = '0;
        else
            r = m >> d;
`ifdef FPALIGN_GRS_EN
        if (int'(d) >= MW)
            lost = |m;
        else
            lost = |(m & ~({MW{1'b1}} << d));
        r[0] = r[0] | lost;
`endif
        return r;
    endfunction

    logic             s1_valid;
    logic             s1_sign_a;
    logic             s1_sign_b;
    logic [EXP_W-1:0] s1_exp_a;
    logic [EXP_W-1:0] s1_exp_b;
    logic [MW-1:0]    s1_man_a;
    logic [MW-1:0]    s1_man_b;
    logic [EXP_W-1:0] s1_diff;
    logic             s1_a_larger;

    logic             s2_valid;
    logic             s2_sign_a;
    logic             s2_sign_b;
    logic [EXP_W-1:0] s2_exp;
    logic             s2_a_larger;
    logic [MW-1:0]    s2_man_a;
    logic [MW-1:0]    s2_man_b;

    logic             s1_load;
    logic             s2_load;

    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [EXP_W-1:0] ea_eff;
    logic [EXP_W-1:0] eb_eff;
    logic [EXP_W-1:0] diff;
    logic             a_ge;

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign bus.in_ready = s1_load;

    assign ea = bus.a[W-2:MAN_W];
    assign eb = bus.b[W-2:MAN_W];
    assign a_ge = ea >= eb;

    // Denormals share the minimum normal exponent for distance purposes.
    assign ea_eff = (|ea) ? ea : EXP_W'(1);
    assign eb_eff = (|eb) ? eb : EXP_W'(1);
    assign diff = a_ge ? (ea_eff - eb_eff) : (eb_eff - ea_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_sign_a   <= 1'b0;
            s1_sign_b   <= 1'b0;
            s1_exp_a    <= '0;
            s1_exp_b    <= '0;
            s1_man_a    <= '0;
            s1_man_b    <= '0;
            s1_diff     <= '0;
            s1_a_larger <= 1'b0;
            s2_valid    <= 1'b0;
            s2_sign_a   <= 1'b0;
            s2_sign_b   <= 1'b0;
            s2_exp      <= '0;
            s2_a_larger <= 1'b0;
            s2_man_a    <= '0;
            s2_man_b    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_a   <= bus.a[W-1];
                    s1_sign_b   <= bus.b[W-1];
                    s1_exp_a    <= ea;
                    s1_exp_b    <= eb;
                    s1_man_a    <= ext(ea, bus.a[MAN_W-1:0]);
                    s1_man_b    <= ext(eb, bus.b[MAN_W-1:0]);
                    s1_diff     <= diff;
                    s1_a_larger <= a_ge;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sign_a   <= s1_sign_a;
                    s2_sign_b   <= s1_sign_b;
                    s2_a_larger <= s1_a_larger;
                    if (s1_a_larger) begin
                        s2_exp   <= s1_exp_a;
                        s2_man_a <= s1_man_a;
                        s2_man_b <= align(s1_man_b, s1_diff);
                    end else begin
                        s2_exp   <= s1_exp_b;
                        s2_man_a <= align(s1_man_a, s1_diff);
                        s2_man_b <= s1_man_b;
                    end
                end
            end
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.sign_a       = s2_sign_a;
    assign bus.sign_b       = s2_sign_b;
    assign bus.exponent_out = s2_exp;
    assign bus.a_larger     = s2_a_larger;
    assign bus.aligned_a    = s2_man_a;
    assign bus.aligned_b    = s2_man_b;
endmodule
